// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle control unit of the 16-bit RISC datapath.
package mc_ctrl_pkg;

  localparam int INSTR_WIDTH = 16;
  localparam int SEL_WIDTH   = 3;

  // Instruction field positions.
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 9;
  localparam int RS_MSB  = 8;
  localparam int RS_LSB  = 6;
  localparam int RT_MSB  = 5;
  localparam int RT_LSB  = 3;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_ADDI = 4'h4;
  localparam logic [3:0] OP_LW   = 4'h5;
  localparam logic [3:0] OP_SW   = 4'h6;
  localparam logic [3:0] OP_BEQ  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  localparam logic [1:0] SRCB_B   = 2'b00;
  localparam logic [1:0] SRCB_ONE = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_WB_ALU   = 4'd7,
    S_WB_MEM   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_HALT     = 4'd11
  } state_t;

  typedef struct packed {
    logic       pc_we;
    logic       ir_we;
    logic       iord;
    logic       mem_re;
    logic       mem_we;
    logic       reg_we;
    logic       mem_to_reg;
    logic       alu_srca;
    logic [1:0] alu_srcb;
    logic [2:0] alu_op;
    logic [1:0] pc_src;
    logic       halted;
  } ctrl_t;

endpackage

// File: rtl/mc_next_state.sv
// Combinational next-state and control decode for the multi-cycle controller.
module mc_next_state
  import mc_ctrl_pkg::*;
(
  input  state_t                 state,
  input  logic [INSTR_WIDTH-1:0] ir,
  input  logic                   zero,
  input  logic                   mem_ready,
  output state_t                 next_state,
  output ctrl_t                  ctrl,
  output logic [SEL_WIDTH-1:0]   wr_sel,
  output logic [SEL_WIDTH-1:0]   rs_sel,
  output logic [SEL_WIDTH-1:0]   rt_sel
);

  logic [3:0] opc;
  logic       unused_imm;

  assign opc        = ir[OPC_MSB:OPC_LSB];
  assign unused_imm = ^ir[2:0];

  // SW stores rd and BEQ compares rd, so both need rd on read port B.
  assign wr_sel = ir[RD_MSB:RD_LSB];
  assign rs_sel = ir[RS_MSB:RS_LSB];
  assign rt_sel = (opc == OP_SW || opc == OP_BEQ) ? ir[RD_MSB:RD_LSB] : ir[RT_MSB:RT_LSB];

  always_comb begin
    // NOTE: defaults first so every path assigns every bit; no latches inferred.
    next_state = S_FETCH;
    ctrl       = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_re   = 1'b1;
        ctrl.alu_srcb = SRCB_ONE;
        ctrl.ir_we    = mem_ready;
        ctrl.pc_we    = mem_ready;
        next_state    = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ctrl.alu_srcb = SRCB_IMM;
        case (opc)
          OP_ADD, OP_SUB, OP_AND, OP_OR: next_state = S_EXEC_R;
          OP_ADDI:                       next_state = S_EXEC_I;
          OP_LW, OP_SW:                  next_state = S_MEM_ADDR;
          OP_BEQ:                        next_state = S_BRANCH;
          OP_JMP:                        next_state = S_JUMP;
          OP_HALT:                       next_state = S_HALT;
          default:                       next_state = S_FETCH;
        endcase
      end
      S_EXEC_R: begin
        ctrl.alu_srca = 1'b1;
        ctrl.alu_srcb = SRCB_B;
        ctrl.alu_op   = {1'b0, opc[1:0]};
        next_state    = S_WB_ALU;
      end
      S_EXEC_I, S_MEM_ADDR: begin
        ctrl.alu_srca = 1'b1;
        ctrl.alu_srcb = SRCB_IMM;
        ctrl.alu_op   = ALU_ADD;
        if (state == S_EXEC_I) next_state = S_WB_ALU;
        else                   next_state = (opc == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        ctrl.iord   = 1'b1;
        ctrl.mem_re = 1'b1;
        next_state  = mem_ready ? S_WB_MEM : S_MEM_RD;
      end
      S_MEM_WR: begin
        ctrl.iord   = 1'b1;
        ctrl.mem_we = 1'b1;
        next_state  = mem_ready ? S_FETCH : S_MEM_WR;
      end
      S_WB_ALU: ctrl.reg_we = 1'b1;
      S_WB_MEM: begin
        ctrl.reg_we     = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_srca = 1'b1;
        ctrl.alu_srcb = SRCB_B;
        ctrl.alu_op   = ALU_SUB;
        ctrl.pc_src   = PC_ALUOUT;
        ctrl.pc_we    = zero;
      end
      S_JUMP: begin
        ctrl.pc_src = PC_JUMP;
        ctrl.pc_we  = 1'b1;
      end
      S_HALT: begin
        ctrl.halted = 1'b1;
        next_state  = S_HALT;
      end
      default: next_state = S_FETCH;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle control unit: state register plus reset gating around mc_next_state.
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int INSTR_W = 16,
  parameter int SEL_W   = 3
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [INSTR_W-1:0] IR,
  input  logic               ZERO,
  input  logic               MEM_READY,
  output logic               PC_WE,
  output logic               IR_WE,
  output logic               IORD,
  output logic               MEM_RE,
  output logic               MEM_WE,
  output logic               REG_WE,
  output logic [SEL_W-1:0]   WR_SEL,
  output logic [SEL_W-1:0]   RS_SEL,
  output logic [SEL_W-1:0]   RT_SEL,
  output logic               MEM_TO_REG,
  output logic               ALU_SRCA,
  output logic [1:0]         ALU_SRCB,
  output logic [2:0]         ALU_OP,
  output logic [1:0]         PC_SRC,
  output logic               HALTED
);

  state_t state;
  state_t next_state;
  ctrl_t  ctrl;

  mc_next_state u_next_state (
    .state      (state),
    .ir         (IR),
    .zero       (ZERO),
    .mem_ready  (MEM_READY),
    .next_state (next_state),
    .ctrl       (ctrl),
    .wr_sel     (WR_SEL),
    .rs_sel     (RS_SEL),
    .rt_sel     (RT_SEL)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    // NOTE: non-blocking update so every reader sees the pre-edge state.
    if (!RST_N) state <= S_FETCH;
    else        state <= next_state;
  end

  // NOTE: reset parks the state in FETCH, which would otherwise request memory;
  // the enables are masked by RST_N so nothing is written or requested in reset.
  assign PC_WE      = ctrl.pc_we  & RST_N;
  assign IR_WE      = ctrl.ir_we  & RST_N;
  assign MEM_RE     = ctrl.mem_re & RST_N;
  assign MEM_WE     = ctrl.mem_we & RST_N;
  assign REG_WE     = ctrl.reg_we & RST_N;
  assign HALTED     = ctrl.halted & RST_N;
  assign IORD       = ctrl.iord;
  assign MEM_TO_REG = ctrl.mem_to_reg;
  assign ALU_SRCA   = ctrl.alu_srca;
  assign ALU_SRCB   = ctrl.alu_srcb;
  assign ALU_OP     = ctrl.alu_op;
  assign PC_SRC     = ctrl.pc_src;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Scoreboard bench for mc_control_fsm: per-cycle expected control vectors are queued with stimulus.
module tb_mc_control_fsm;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [15:0] IR;
  logic       ZERO;
  logic       MEM_READY;
  logic       PC_WE, IR_WE, IORD, MEM_RE, MEM_WE, REG_WE, MEM_TO_REG, ALU_SRCA, HALTED;
  logic [2:0] WR_SEL, RS_SEL, RT_SEL, ALU_OP;
  logic [1:0] ALU_SRCB, PC_SRC;

  mc_control_fsm dut (
    .CLK(CLK), .RST_N(RST_N), .IR(IR), .ZERO(ZERO), .MEM_READY(MEM_READY),
    .PC_WE(PC_WE), .IR_WE(IR_WE), .IORD(IORD), .MEM_RE(MEM_RE), .MEM_WE(MEM_WE),
    .REG_WE(REG_WE), .WR_SEL(WR_SEL), .RS_SEL(RS_SEL), .RT_SEL(RT_SEL),
    .MEM_TO_REG(MEM_TO_REG), .ALU_SRCA(ALU_SRCA), .ALU_SRCB(ALU_SRCB),
    .ALU_OP(ALU_OP), .PC_SRC(PC_SRC), .HALTED(HALTED)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] ir;
    logic        zero;
    logic        rdy;
  } stim_t;

  stim_t       stim_q[$];
  logic [15:0] exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  bit          sb_pending = 0;
  string       cur_test = "none";

  // Vector order: pc_we ir_we iord mem_re mem_we reg_we mem_to_reg alu_srca srcb[2] op[3] pc_src[2] halted
  function automatic logic [15:0] mk(input logic pc_we, ir_we, iord, mem_re, mem_we, reg_we,
                                     m2r, srca, input logic [1:0] srcb, input logic [2:0] op,
                                     input logic [1:0] pcsrc, input logic halted);
    return {pc_we, ir_we, iord, mem_re, mem_we, reg_we, m2r, srca, srcb, op, pcsrc, halted};
  endfunction

  function automatic logic [15:0] v_fetch(input logic rdy);
    return mk(rdy, rdy, 0, 1, 0, 0, 0, 0, 2'b01, 3'b000, 2'b00, 0);
  endfunction
  function automatic logic [15:0] v_decode();
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 3'b000, 2'b00, 0);
  endfunction
  function automatic logic [15:0] v_exec_r(input logic [2:0] op);
    return mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b00, op, 2'b00, 0);
  endfunction
  function automatic logic [15:0] v_addr();
    return mk(0, 0, 0, 0, 0, 0, 0, 1, 2'b10, 3'b000, 2'b00, 0);
  endfunction
  function automatic logic [15:0] v_mem_rd();
    return mk(0, 0, 1, 1, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 0);
  endfunction
  function automatic logic [15:0] v_mem_wr();
    return mk(0, 0, 1, 0, 1, 0, 0, 0, 2'b00, 3'b000, 2'b00, 0);
  endfunction
  function automatic logic [15:0] v_wb(input logic m2r);
    return mk(0, 0, 0, 0, 0, 1, m2r, 0, 2'b00, 3'b000, 2'b00, 0);
  endfunction
  function automatic logic [15:0] v_branch(input logic z);
    return mk(z, 0, 0, 0, 0, 0, 0, 1, 2'b00, 3'b001, 2'b01, 0);
  endfunction
  function automatic logic [15:0] v_jump();
    return mk(1, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b10, 0);
  endfunction
  function automatic logic [15:0] v_halt();
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 2'b00, 1);
  endfunction

  task automatic push(input logic [15:0] ir, input logic z, input logic r, input logic [15:0] e);
    stim_q.push_back('{ir: ir, zero: z, rdy: r});
    exp_q.push_back(e);
  endtask

  // Expected per-cycle sequence of one instruction, starting at its FETCH.
  task automatic push_instr(input logic [15:0] ir, input logic z, input int f_stall, input int m_stall);
    logic [3:0] opc;
    opc = ir[15:12];
    for (int i = 0; i < f_stall; i++) push(ir, z, 1'b0, v_fetch(1'b0));
    push(ir, z, 1'b1, v_fetch(1'b1));
    push(ir, z, 1'b1, v_decode());
    case (opc)
      4'h0, 4'h1, 4'h2, 4'h3: begin
        push(ir, z, 1'b1, v_exec_r({1'b0, opc[1:0]}));
        push(ir, z, 1'b1, v_wb(1'b0));
      end
      4'h4: begin
        push(ir, z, 1'b1, v_addr());
        push(ir, z, 1'b1, v_wb(1'b0));
      end
      4'h5: begin
        push(ir, z, 1'b1, v_addr());
        for (int i = 0; i < m_stall; i++) push(ir, z, 1'b0, v_mem_rd());
        push(ir, z, 1'b1, v_mem_rd());
        push(ir, z, 1'b1, v_wb(1'b1));
      end
      4'h6: begin
        push(ir, z, 1'b1, v_addr());
        for (int i = 0; i < m_stall; i++) push(ir, z, 1'b0, v_mem_wr());
        push(ir, z, 1'b1, v_mem_wr());
      end
      4'h7: push(ir, z, 1'b1, v_branch(z));
      4'h8: push(ir, z, 1'b1, v_jump());
      4'hF: push(ir, z, 1'b1, v_halt());
      default: ;
    endcase
  endtask

  // Drive one queued stimulus per cycle; the monitor compares at the falling edge.
  task automatic run_queued();
    stim_t s;
    while (stim_q.size() > 0) begin
      s = stim_q.pop_front();
      IR = s.ir;
      ZERO = s.zero;
      MEM_READY = s.rdy;
      sb_pending = 1;
      @(posedge CLK);
      #1;
    end
  endtask

  always @(negedge CLK) begin
    logic [15:0] obs, e;
    if (sb_pending) begin
      sb_pending = 0;
      cyc++;
      obs = {PC_WE, IR_WE, IORD, MEM_RE, MEM_WE, REG_WE, MEM_TO_REG, ALU_SRCA,
             ALU_SRCB, ALU_OP, PC_SRC, HALTED};
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL %s cycle %0d: scoreboard empty, outputs=%h", cur_test, cyc, obs);
      end else begin
        e = exp_q.pop_front();
        if (obs !== e) begin
          n_errors++;
          $display("FAIL %s cycle %0d: outputs=%h required=%h", cur_test, cyc, obs, e);
        end
      end
    end
  end

  task automatic test_sel(input logic [15:0] ir, input logic [2:0] rs, rt, wr);
    IR = ir;
    #1;
    n_checks++;
    if ({RS_SEL, RT_SEL, WR_SEL} !== {rs, rt, wr}) begin
      n_errors++;
      $display("FAIL sel ir=%h: rs/rt/wr=%0d/%0d/%0d required=%0d/%0d/%0d",
               ir, RS_SEL, RT_SEL, WR_SEL, rs, rt, wr);
    end
  endtask

  task automatic check_reset_quiet(input string name);
    n_checks++;
    if ({PC_WE, IR_WE, MEM_RE, MEM_WE, REG_WE, HALTED} !== 6'b0) begin
      n_errors++;
      $display("FAIL %s: enables pc/ir/re/we/reg/halt=%b required=000000", name,
               {PC_WE, IR_WE, MEM_RE, MEM_WE, REG_WE, HALTED});
    end
  endtask

  task automatic test_reset();
    cur_test = "reset";
    RST_N = 1'b0; IR = 16'h0650; ZERO = 1'b0; MEM_READY = 1'b1;
    #12;
    check_reset_quiet("reset_quiet");
    @(posedge CLK); #1;
    RST_N = 1'b1;
  endtask

  task automatic test_r_type();
    cur_test = "r_type";
    test_sel(16'h0650, 3'd1, 3'd2, 3'd3);
    for (int op = 0; op < 4; op++) push_instr({op[3:0], 12'h650}, 1'b0, 0, 0);
    run_queued();
  endtask

  task automatic test_addi();
    cur_test = "addi";
    push_instr(16'h4A45, 1'b0, 0, 0);
    run_queued();
  endtask

  task automatic test_lw();
    cur_test = "lw";
    test_sel(16'h5445, 3'd1, 3'd0, 3'd2);
    push_instr(16'h5445, 1'b0, 0, 2);
    run_queued();
  endtask

  task automatic test_sw();
    cur_test = "sw";
    test_sel(16'h6A42, 3'd1, 3'd5, 3'd5);
    push_instr(16'h6A42, 1'b0, 0, 1);
    run_queued();
  endtask

  task automatic test_beq();
    cur_test = "beq";
    test_sel(16'h7203, 3'd0, 3'd1, 3'd1);
    push_instr(16'h7203, 1'b1, 0, 0);
    push_instr(16'h7203, 1'b0, 0, 0);
    run_queued();
  endtask

  task automatic test_jmp_nop();
    cur_test = "jmp_nop";
    push_instr(16'h9000, 1'b0, 0, 0);
    push_instr(16'h8123, 1'b0, 0, 0);
    push_instr(16'hC000, 1'b0, 0, 0);
    push_instr(16'h4000, 1'b0, 0, 0);
    run_queued();
  endtask

  task automatic test_fetch_wait();
    cur_test = "fetch_wait";
    push_instr(16'h0650, 1'b0, 3, 0);
    run_queued();
  endtask

  task automatic test_back_to_back();
    logic [3:0] opc;
    cur_test = "back_to_back";
    for (int i = 0; i < 10; i++) begin
      opc = 4'($urandom_range(0, 9));
      push_instr({opc, 12'($urandom)}, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));
    end
    run_queued();
  endtask

  task automatic test_reset_mid_write();
    cur_test = "reset_mid_write";
    push_instr(16'h6A42, 1'b0, 0, 1);
    void'(stim_q.pop_back());
    void'(exp_q.pop_back());
    run_queued();
    n_checks++;
    if (MEM_WE !== 1'b1) begin
      n_errors++;
      $display("FAIL mem_we_before_reset: MEM_WE=%b required=1", MEM_WE);
    end
    RST_N = 1'b0;
    #1;
    check_reset_quiet("reset_mid_write");
    @(posedge CLK); #1;
    RST_N = 1'b1;
    push_instr(16'h0650, 1'b0, 0, 0);
    run_queued();
  endtask

  task automatic test_halt();
    cur_test = "halt";
    push_instr(16'hF000, 1'b0, 0, 0);
    for (int i = 0; i < 4; i++) push(16'h0650, i[0], i[1], v_halt());
    run_queued();
    RST_N = 1'b0;
    #1;
    check_reset_quiet("halt_reset");
    @(posedge CLK); #1;
    RST_N = 1'b1;
    cur_test = "after_halt";
    push_instr(16'h8000, 1'b0, 0, 0);
    run_queued();
  endtask

  initial begin
    test_reset();
    test_r_type();
    test_addi();
    test_lw();
    test_sw();
    test_beq();
    test_jmp_nop();
    test_fetch_wait();
    test_back_to_back();
    test_reset_mid_write();
    test_halt();
    @(negedge CLK);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_leftover: remaining=%0d required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
